// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: receiver state encodings and receive-FIFO sizing.
package uart_rx_fifo_pkg;

    localparam int UART_RX_FIFO_DEPTH = 16;
    localparam int UART_RX_FIFO_AW    = 4;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_CLEANUP = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver/bus side signals of the receive FIFO; master drives strobes, slave is the FIFO.
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int ADDR_W = UART_RX_FIFO_AW
);
    logic              i_Rx_DV;
    logic [7:0]        i_Rx_Byte;
    logic              i_Rd;
    logic              i_Clr_Ovr;
    logic              i_Flush;
    logic [7:0]        o_Rd_Data;
    logic [ADDR_W:0]   o_Count;
    logic              o_Empty;
    logic              o_Full;
    logic              o_Ovr;
    logic              o_Irq;

    modport master (
        output i_Rx_DV, i_Rx_Byte, i_Rd, i_Clr_Ovr, i_Flush,
        input  o_Rd_Data, o_Count, o_Empty, o_Full, o_Ovr, o_Irq
    );

    modport slave (
        input  i_Rx_DV, i_Rx_Byte, i_Rd, i_Clr_Ovr, i_Flush,
        output o_Rd_Data, o_Count, o_Empty, o_Full, o_Ovr, o_Irq
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x W register file: one synchronous write port, one asynchronous read port.
module uart_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int W      = 8
) (
    input  logic              i_Clock,
    input  logic              i_We,
    input  logic [ADDR_W-1:0] i_Waddr,
    input  logic [W-1:0]      i_Wdata,
    input  logic [ADDR_W-1:0] i_Raddr,
    output logic [W-1:0]      o_Rdata
);
    // Contents are intentionally not reset; occupancy tracking masks stale entries.
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge i_Clock) begin
        if (i_We) mem_q[i_Waddr] <= i_Wdata;
    end

    assign o_Rdata = mem_q[i_Raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between UART receiver and peripheral bus: first-word-fall-through head,
// occupancy, sticky overrun and interrupt level.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int ADDR_W = UART_RX_FIFO_AW
) (
    input  logic           i_Clock,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              ovr_q,    ovr_d;

    logic       empty, full, rd_ok, we, mem_we;
    logic [7:0] head;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_CNT);
    assign rd_ok  = bus.i_Rd & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign we     = bus.i_Rx_DV & (~full | rd_ok);
    assign mem_we = we & ~bus.i_Flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.i_Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (we)    wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({we, rd_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Set beats clear; flush leaves the flag alone and drops the byte silently.
    always_comb begin
        ovr_d = ovr_q;
        if (bus.i_Rx_DV & full & ~rd_ok & ~bus.i_Flush) ovr_d = 1'b1;
        else if (bus.i_Clr_Ovr)                          ovr_d = 1'b0;
    end

    always_ff @(posedge i_Clock or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .W      (8)
    ) u_mem (
        .i_Clock (i_Clock),
        .i_We    (mem_we),
        .i_Waddr (wr_ptr_q),
        .i_Wdata (bus.i_Rx_Byte),
        .i_Raddr (rd_ptr_q),
        .o_Rdata (head)
    );

    assign bus.o_Rd_Data = empty ? 8'h00 : head;
    assign bus.o_Count   = count_q;
    assign bus.o_Empty   = empty;
    assign bus.o_Full    = full;
    assign bus.o_Ovr     = ovr_q;
    assign bus.o_Irq     = ~empty | ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table plus hand sequences for full/overrun/wrap/reset.
module tb_uart_rx_fifo;
    logic i_Clock = 1'b0;
    logic rst     = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    uart_rx_fifo_if #(.ADDR_W(4)) bus ();

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .i_Clock (i_Clock),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 i_Clock = ~i_Clock;

    typedef struct {
        logic       dv;
        logic [7:0] b;
        logic       rd;
        logic       clr;
        logic       flush;
        int         cnt;
        logic [7:0] data;
        logic       empty;
        logic       full;
        logic       ovr;
        logic       irq;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int cnt, input logic [7:0] d,
                           input logic e, input logic f, input logic o, input logic irq);
        chk({tag, "_count"}, 32'(bus.o_Count), 32'(cnt));
        chk({tag, "_data"},  32'(bus.o_Rd_Data), 32'(d));
        chk({tag, "_empty"}, 32'(bus.o_Empty), 32'(e));
        chk({tag, "_full"},  32'(bus.o_Full), 32'(f));
        chk({tag, "_ovr"},   32'(bus.o_Ovr), 32'(o));
        chk({tag, "_irq"},   32'(bus.o_Irq), 32'(irq));
    endtask

    task automatic idle();
        bus.i_Rx_DV = 0; bus.i_Rx_Byte = 8'h00; bus.i_Rd = 0;
        bus.i_Clr_Ovr = 0; bus.i_Flush = 0;
    endtask

    // Apply the given strobes for one edge, then release them.
    task automatic step(input logic dv, input logic [7:0] b, input logic rd,
                        input logic clr, input logic flush);
        bus.i_Rx_DV = dv; bus.i_Rx_Byte = b; bus.i_Rd = rd;
        bus.i_Clr_Ovr = clr; bus.i_Flush = flush;
        @(posedge i_Clock); #1;
        idle();
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 16; i++) step(1, base + 8'(i), 0, 0, 0);
    endtask

    initial begin
        logic [7:0] q[$];
        int sent, got, cyc;
        logic dv, rd;
        logic [7:0] b;

        //            dv  b      rd clr fl  cnt data   e  f  o  irq
        tbl[0]  = '{1, 8'hA5, 0, 0, 0, 1, 8'hA5, 0, 0, 0, 1};
        tbl[1]  = '{1, 8'h3C, 0, 0, 0, 2, 8'hA5, 0, 0, 0, 1};
        tbl[2]  = '{1, 8'h0F, 0, 0, 0, 3, 8'hA5, 0, 0, 0, 1};
        tbl[3]  = '{0, 8'h00, 1, 0, 0, 2, 8'h3C, 0, 0, 0, 1};
        tbl[4]  = '{0, 8'h00, 1, 0, 0, 1, 8'h0F, 0, 0, 0, 1};
        tbl[5]  = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0};
        tbl[6]  = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0};
        tbl[7]  = '{1, 8'h77, 1, 0, 0, 1, 8'h77, 0, 0, 0, 1};
        tbl[8]  = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0};
        tbl[9]  = '{1, 8'h01, 0, 0, 0, 1, 8'h01, 0, 0, 0, 1};
        tbl[10] = '{1, 8'h02, 0, 0, 0, 2, 8'h01, 0, 0, 0, 1};
        tbl[11] = '{1, 8'h03, 0, 0, 0, 3, 8'h01, 0, 0, 0, 1};
        tbl[12] = '{1, 8'h04, 0, 0, 0, 4, 8'h01, 0, 0, 0, 1};
        tbl[13] = '{1, 8'h05, 0, 0, 0, 5, 8'h01, 0, 0, 0, 1};
        tbl[14] = '{1, 8'h99, 0, 0, 1, 0, 8'h00, 1, 0, 0, 0};
        tbl[15] = '{1, 8'h42, 0, 0, 0, 1, 8'h42, 0, 0, 0, 1};

        idle();
        #2;
        chk_all("reset", 0, 8'h00, 1, 0, 0, 0);
        @(negedge i_Clock); rst = 0;
        @(posedge i_Clock); #1;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].dv, tbl[i].b, tbl[i].rd, tbl[i].clr, tbl[i].flush);
            chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].data,
                    tbl[i].empty, tbl[i].full, tbl[i].ovr, tbl[i].irq);
        end
        step(0, 8'h00, 0, 0, 1);

        // Fill, overflow, drain in order without the dropped byte.
        fill(8'h00);
        chk_all("full", 16, 8'h00, 0, 1, 0, 1);
        step(1, 8'hFF, 0, 0, 0);
        chk_all("ovf", 16, 8'h00, 0, 1, 1, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), 32'(bus.o_Rd_Data), 32'(i));
            step(0, 8'h00, 1, 0, 0);
        end
        chk_all("drained", 0, 8'h00, 1, 0, 1, 1);
        step(0, 8'h00, 0, 1, 0);
        chk_all("clr", 0, 8'h00, 1, 0, 0, 0);

        // Full with simultaneous write and pop.
        fill(8'h10);
        step(1, 8'h55, 1, 0, 0);
        chk_all("full_wr_rd", 16, 8'h11, 0, 1, 0, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_b%0d", i), 32'(bus.o_Rd_Data),
                (i == 15) ? 32'h55 : 32'(8'h11 + i));
            step(0, 8'h00, 1, 0, 0);
        end
        chk("drain_b_empty", 32'(bus.o_Empty), 32'd1);

        // Overrun set beats clear in the same cycle.
        fill(8'h20);
        step(1, 8'hAA, 0, 1, 0);
        chk("ovr_set_wins", 32'(bus.o_Ovr), 32'd1);
        step(0, 8'h00, 0, 1, 0);
        chk("ovr_cleared", 32'(bus.o_Ovr), 32'd0);
        chk("ovr_cleared_cnt", 32'(bus.o_Count), 32'd16);
        step(1, 8'hBB, 0, 0, 1);
        chk_all("flush_full", 0, 8'h00, 1, 0, 0, 0);

        // Interleaved traffic against a scoreboard, wrapping the pointers.
        sent = 0; got = 0; cyc = 0;
        while (got < 40 && cyc < 2000) begin
            dv = (sent < 40) && (q.size() < 16) && ($urandom_range(0, 2) != 0);
            rd = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            b  = 8'($urandom);
            if (rd) chk("wrap_data", 32'(bus.o_Rd_Data), 32'(q[0]));
            step(dv, b, rd, 0, 0);
            if (rd) begin void'(q.pop_front()); got++; end
            if (dv) begin q.push_back(b); sent++; end
            chk("wrap_count", 32'(bus.o_Count), 32'(q.size()));
            cyc++;
        end
        chk("wrap_done", 32'(got), 32'd40);

        // Reset mid-stream with entries present.
        for (int i = 0; i < 7; i++) step(1, 8'hC0 + 8'(i), 0, 0, 0);
        step(1, 8'hEE, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 8'hD0, 0, 0, 0);
        chk("pre_rst_ovr", 32'(bus.o_Ovr), 32'd1);
        for (int i = 0; i < 9; i++) step(0, 8'h00, 1, 0, 0);
        chk("pre_rst_cnt", 32'(bus.o_Count), 32'd7);
        #2; rst = 1; #1;
        chk_all("rst_mid", 0, 8'h00, 1, 0, 0, 0);
        @(negedge i_Clock); rst = 0;
        step(1, 8'h5A, 0, 0, 0);
        chk_all("post_rst", 1, 8'h5A, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
